// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_arbiter_pkg                                             |
// | Brief  : Shared types and defaults for the ALU arbiter slice:        |
// |          ALU opcode enum, registered flag bundle, requester count.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package alu_arbiter_pkg;

    // Default requester count and datapath width.
    localparam int ALU_ARB_NREQ  = 2;
    localparam int ALU_ARB_WIDTH = 32;

    // ALU operation codes shared with the datapath ALU.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_REM  = 4'd12
    } aluop_t;

    // Condition flags as produced by the ALU.
    typedef struct packed {
        logic carry;
        logic overflow;
        logic neg;
        logic zero;
    } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_rr_picker                                               |
// | Brief  : Combinational round-robin priority picker. Returns the      |
// |          first valid index found searching i_ptr, i_ptr+1, ... with  |
// |          wrap, as a one-hot vector and as a binary index.            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module alu_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // One extra bit so the wrap compare never overflows.
    logic [IDX_W:0] w_pos;

    // Walk the requesters starting at the pointer and stop at the first valid one.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
                w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
            end
            if (!o_any && i_valid[w_pos[IDX_W-1:0]]) begin
                o_any                       = 1'b1;
                o_grant[w_pos[IDX_W-1:0]]   = 1'b1;
                o_idx                       = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_arbiter                                                 |
// | Brief  : Round-robin arbiter sharing one combinational ALU among     |
// |          NUM_REQ requesters. Valid/ready request and response        |
// |          channels; result and flags are registered (1-cycle latency).|
// |          Optional ALU_ARB_LOCK_EN: a granted requester holding       |
// |          req_lock keeps priority for its next operation.             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = ALU_ARB_NREQ,
    parameter int BIT_WIDTH = ALU_ARB_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  aluop_t [NUM_REQ-1:0]              req_op,
    input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0] req_in1,
    input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0] req_in2,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]                req_lock,
`endif
    output logic [NUM_REQ-1:0]                rsp_valid,
    input  logic [NUM_REQ-1:0]                rsp_ready,
    output logic [BIT_WIDTH-1:0]              rsp_out,
    output alu_flags_t                        rsp_flags,
    output aluop_t                            alu_op,
    output logic [BIT_WIDTH-1:0]              alu_in1,
    output logic [BIT_WIDTH-1:0]              alu_in2,
    input  logic [BIT_WIDTH-1:0]              alu_out,
    input  logic                              alu_carry,
    input  logic                              alu_overflow,
    input  logic                              alu_neg,
    input  logic                              alu_zero
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_resp = 1'b1;

    logic [0:0]           r_state;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_idx_w-1:0]   r_owner;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [BIT_WIDTH-1:0] r_rsp_out;
    alu_flags_t           r_rsp_flags;

    logic [NUM_REQ-1:0]   w_onehot;
    logic [c_idx_w-1:0]   w_idx;
    logic [c_idx_w-1:0]   w_rr_inc;
    logic [c_idx_w-1:0]   w_ptr_next;
    logic                 w_any;
    logic                 w_can_accept;
    logic                 w_grant;

    alu_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_picker (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_onehot),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // A new op can start when idle, or when the owner drains its result this cycle.
    assign w_can_accept = (r_state == c_idle) ||
                          ((r_state == c_resp) && rsp_ready[r_owner]);
    assign w_grant      = w_can_accept && w_any;
    assign req_ready    = w_grant ? w_onehot : '0;

    assign w_rr_inc = (w_idx == c_idx_w'(NUM_REQ - 1)) ? '0 : w_idx + c_idx_w'(1);

`ifdef ALU_ARB_LOCK_EN
    // A locking requester restarts the search at itself so it wins again next time.
    assign w_ptr_next = req_lock[w_idx] ? w_idx : w_rr_inc;
`else
    assign w_ptr_next = w_rr_inc;
`endif

    // Route the granted requester to the ALU; park it on ADD 0+0 otherwise.
    always_comb begin
        alu_op  = ALU_ADD;
        alu_in1 = '0;
        alu_in2 = '0;
        if (w_grant) begin
            alu_op  = req_op[w_idx];
            alu_in1 = req_in1[w_idx];
            alu_in2 = req_in2[w_idx];
        end
    end

    // IDLE/RESP control, round-robin pointer and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_rsp_valid <= '0;
            r_rsp_out   <= '0;
            r_rsp_flags <= '0;
        end else if (w_grant) begin
            r_state     <= c_resp;
            r_owner     <= w_idx;
            r_rr_ptr    <= w_ptr_next;
            r_rsp_valid <= w_onehot;
            r_rsp_out   <= alu_out;
            r_rsp_flags <= {alu_carry, alu_overflow, alu_neg, alu_zero};
        end else if ((r_state == c_resp) && rsp_ready[r_owner]) begin
            r_state     <= c_idle;
            r_rsp_valid <= '0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_out   = r_rsp_out;
    assign rsp_flags = r_rsp_flags;

endmodule
`default_nettype wire
